// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   ADDR_W / DATA_W / NUM_REGS : default register-file geometry
//   REG_ZERO                   : hard-wired zero register, never written or tracked
//   req_idx_e                  : requester index, also used as the round-robin pointer
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

  // The requester that did not win a contested grant; priority moves to it.
  function automatic req_idx_e rr_loser(input req_idx_e winner);
    return (winner == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
//   clk, rst                  : clock, synchronous active-high reset (clears all bits)
//   set_valid_i, set_addr_i   : issue-stage reservation, marks a register pending
//   clr_valid_i, clr_addr_i   : write-port commit, releases a register
//   chk_addrN_i / chk_busyN_o : two combinational lookups for the decode stage
// A set and a clear of the same register on one edge leaves it busy: the reservation
// belongs to a newer producer than the write that is completing.
module regfile_scoreboard #(
  parameter int unsigned ADDR_W   = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = regfile_wb_arbiter_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_valid_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] chk_addr1_i,
  input  logic [ADDR_W-1:0] chk_addr2_i,
  output logic              chk_busy1_o,
  output logic              chk_busy2_o
);
  import regfile_wb_arbiter_pkg::*;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    // Applied after the clear so a same-edge reservation wins.
    if (set_valid_i && (set_addr_i != ADDR_W'(REG_ZERO))) begin
      busy_d[set_addr_i] = 1'b1;
    end
    // The zero register never has a pending producer.
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Reads the registered bits: a register being written this cycle still reports busy
  // because the RegFile has not captured the data yet.
  assign chk_busy1_o = busy_q[chk_addr1_i];
  assign chk_busy2_o = busy_q[chk_addr2_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single RegFile write port, with pending-write scoreboard.
//   clk, rst                     : clock, synchronous active-high reset
//   req0_* (valid/addr/data/ready): ALU write-back requester
//   req1_* (valid/addr/data/ready): load / multicycle write-back requester
//   rsv_valid, rsv_addr          : issue-stage destination reservation
//   chk_addrN, chk_busyN         : decode-stage RAW hazard lookups
//   Ctrl_regWr, Write_import, Write_data : registered RegFile write port
// A grant in cycle N appears on the write port in cycle N+1. Grants to register 0 are
// accepted and take part in arbitration but never raise Ctrl_regWr.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W     = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              Ctrl_regWr,
  output logic [ADDR_W-1:0] Write_import,
  output logic [DATA_W-1:0] Write_data
);
  import regfile_wb_arbiter_pkg::*;

  localparam req_idx_e PrioInit = (PRIO_RESET == 0) ? REQ_ALU : REQ_MEM;

  req_idx_e          prio_q, prio_d;
  logic              contested;
  logic              grant0, grant1, any_grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Grant decode. Nothing is accepted while in reset.
  always_comb begin
    contested = req0_valid & req1_valid;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!rst) begin
      if (contested) begin
        grant0 = (prio_q == REQ_ALU);
        grant1 = (prio_q == REQ_MEM);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    any_grant  = grant0 | grant1;
    grant_addr = grant1 ? req1_addr : req0_addr;
    grant_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Priority only moves after a contested grant; the holder always wins those.
  always_comb begin
    prio_d = prio_q;
    if (contested && !rst) begin
      prio_d = rr_loser(prio_q);
    end
  end

  // Output stage: address/data hold when idle so the RegFile port stays quiet.
  always_comb begin
    wr_en_d   = any_grant && (grant_addr != ADDR_W'(REG_ZERO));
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (any_grant) begin
      wr_addr_d = grant_addr;
      wr_data_d = grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= PrioInit;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign Ctrl_regWr   = wr_en_q;
  assign Write_import = wr_addr_q;
  assign Write_data   = wr_data_q;

  // Busy bits clear on the edge that ends the write-port cycle, i.e. when RegFile commits.
  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (1 << ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (rsv_valid),
    .set_addr_i  (rsv_addr),
    .clr_valid_i (wr_en_q),
    .clr_addr_i  (wr_addr_q),
    .chk_addr1_i (chk_addr1),
    .chk_addr2_i (chk_addr2),
    .chk_busy1_o (chk_busy1),
    .chk_busy2_o (chk_busy2)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention, scoreboard,
// set/clear race, register zero and reset during an in-flight write.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, rsv_valid;
  logic [4:0]  req0_addr, req1_addr, rsv_addr, chk_addr1, chk_addr2;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, chk_busy1, chk_busy2;
  logic        Ctrl_regWr;
  logic [4:0]  Write_import;
  logic [31:0] Write_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .PRIO_RESET (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .chk_addr1    (chk_addr1),
    .chk_addr2    (chk_addr2),
    .chk_busy1    (chk_busy1),
    .chk_busy2    (chk_busy2),
    .Ctrl_regWr   (Ctrl_regWr),
    .Write_import (Write_import),
    .Write_data   (Write_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1 time unit after the edge, checks at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsv_valid  = 1'b0;
  endtask

  initial begin
    // Reset with both requesters asking: nothing accepted.
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2222_2222;
    rsv_valid = 1'b0; rsv_addr = 5'd0; chk_addr1 = 5'd3; chk_addr2 = 5'd4;
    #1;
    chk("rst_ready0_c0", 32'(req0_ready), 32'd0);
    chk("rst_ready1_c0", 32'(req1_ready), 32'd0);
    tick(); #1;
    chk("rst_ready0_c1", 32'(req0_ready), 32'd0);
    chk("rst_ready1_c1", 32'(req1_ready), 32'd0);
    chk("rst_wr_c1", 32'(Ctrl_regWr), 32'd0);
    chk("rst_busy1_c1", 32'(chk_busy1), 32'd0);
    chk("rst_busy2_c1", 32'(chk_busy2), 32'd0);
    tick();
    rst = 1'b0; idle();
    #1;
    chk("rst_wr_c2", 32'(Ctrl_regWr), 32'd0);
    chk("rst_addr_c2", 32'(Write_import), 32'd0);
    chk("rst_data_c2", Write_data, 32'd0);

    // Single uncontested write.
    tick();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEAD_BEEF;
    #1;
    chk("single_ready0", 32'(req0_ready), 32'd1);
    chk("single_ready1", 32'(req1_ready), 32'd0);
    tick(); idle(); #1;
    chk("single_wr", 32'(Ctrl_regWr), 32'd1);
    chk("single_addr", 32'(Write_import), 32'd3);
    chk("single_data", Write_data, 32'hDEAD_BEEF);
    tick(); #1;
    chk("single_wr_off", 32'(Ctrl_regWr), 32'd0);
    chk("single_addr_hold", 32'(Write_import), 32'd3);
    chk("single_data_hold", Write_data, 32'hDEAD_BEEF);

    // Contention for four cycles: grants alternate 0,1,0,1.
    tick();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hAAAA_0004;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hBBBB_0005;
    #1;
    chk("cont1_ready0", 32'(req0_ready), 32'd1);
    chk("cont1_ready1", 32'(req1_ready), 32'd0);
    tick(); #1;
    chk("cont2_ready0", 32'(req0_ready), 32'd0);
    chk("cont2_ready1", 32'(req1_ready), 32'd1);
    chk("cont2_addr", 32'(Write_import), 32'd4);
    chk("cont2_data", Write_data, 32'hAAAA_0004);
    tick(); #1;
    chk("cont3_ready0", 32'(req0_ready), 32'd1);
    chk("cont3_wr", 32'(Ctrl_regWr), 32'd1);
    chk("cont3_addr", 32'(Write_import), 32'd5);
    chk("cont3_data", Write_data, 32'hBBBB_0005);
    tick(); #1;
    chk("cont4_ready1", 32'(req1_ready), 32'd1);
    chk("cont4_addr", 32'(Write_import), 32'd4);
    tick(); idle(); #1;
    chk("cont5_wr", 32'(Ctrl_regWr), 32'd1);
    chk("cont5_addr", 32'(Write_import), 32'd5);
    chk("cont5_data", Write_data, 32'hBBBB_0005);

    // Uncontested req1 grant must not move priority (still with req0).
    tick();
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h0000_0006;
    #1;
    chk("unc_ready1", 32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h0000_000A;
    req1_addr = 5'd11; req1_data = 32'h0000_000B;
    #1;
    chk("unc_prio_ready0", 32'(req0_ready), 32'd1);
    chk("unc_prio_ready1", 32'(req1_ready), 32'd0);
    chk("unc_addr", 32'(Write_import), 32'd6);
    tick(); idle(); #1;
    chk("unc_win_addr", 32'(Write_import), 32'd10);

    // Scoreboard: reserve r7, write it back two cycles later.
    tick();
    rsv_valid = 1'b1; rsv_addr = 5'd7; chk_addr1 = 5'd7;
    #1;
    chk("sb_busy_before", 32'(chk_busy1), 32'd0);
    tick(); rsv_valid = 1'b0; #1;
    chk("sb_busy_set", 32'(chk_busy1), 32'd1);
    tick();
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_0077;
    #1;
    chk("sb_ready1", 32'(req1_ready), 32'd1);
    chk("sb_busy_req", 32'(chk_busy1), 32'd1);
    tick(); idle(); #1;
    chk("sb_wr", 32'(Ctrl_regWr), 32'd1);
    chk("sb_wr_addr", 32'(Write_import), 32'd7);
    chk("sb_busy_during_wr", 32'(chk_busy1), 32'd1);
    tick(); #1;
    chk("sb_busy_cleared", 32'(chk_busy1), 32'd0);

    // Set/clear race on r9: reservation lands on the commit edge.
    tick();
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0099; chk_addr2 = 5'd9;
    #1;
    chk("race_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1;
    chk("race_wr", 32'(Ctrl_regWr), 32'd1);
    chk("race_wr_addr", 32'(Write_import), 32'd9);
    tick(); idle(); #1;
    chk("race_busy_kept", 32'(chk_busy2), 32'd1);
    tick(); #1;
    chk("race_busy_still", 32'(chk_busy2), 32'd1);

    // Register zero: granted, never written, never busy.
    tick();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0000_1234;
    rsv_valid = 1'b1; rsv_addr = 5'd0; chk_addr1 = 5'd0;
    #1;
    chk("zero_ready0", 32'(req0_ready), 32'd1);
    chk("zero_busy_now", 32'(chk_busy1), 32'd0);
    tick(); idle(); #1;
    chk("zero_wr", 32'(Ctrl_regWr), 32'd0);
    chk("zero_busy_after", 32'(chk_busy1), 32'd0);

    // Reset while a write is in flight: dropped, scoreboard cleared.
    tick();
    rsv_valid = 1'b1; rsv_addr = 5'd13; chk_addr1 = 5'd13;
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h0000_00CC;
    #1;
    chk("mid_ready0", 32'(req0_ready), 32'd1);
    tick();
    rsv_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_wr_inflight", 32'(Ctrl_regWr), 32'd1);
    chk("mid_busy13", 32'(chk_busy1), 32'd1);
    chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
    tick();
    rst = 1'b0; idle();
    #1;
    chk("mid_wr_dropped", 32'(Ctrl_regWr), 32'd0);
    chk("mid_addr_reset", 32'(Write_import), 32'd0);
    chk("mid_busy_cleared", 32'(chk_busy1), 32'd0);
    chk("mid_busy9_cleared", 32'(chk_busy2), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
